// File: rtl/io_format_decode.sv
// Slow-out format stage: splits serial slow-out data into digits, decodes per-digit format codes,
// drives the I/O flags and queues characters. Build macro IO_FMT_PARITY_EN adds odd parity in char_data[5].
module io_format_decode #(
  parameter int DEPTH = 4
) (
  input  logic       CLOCK,
  input  logic       rst_n,
  input  logic       T0,
  input  logic       SLOW_OUT,
  input  logic       DATA_BIT,
  input  logic       FMT_BIT,
  input  logic       DIGIT_STB,
  input  logic       FMT_STB,
  input  logic       char_ready,
  output logic       DIGIT_OF,
  output logic       WAIT_OF,
  output logic       CR_TAB_OF,
  output logic       STOP_OF,
  output logic       char_valid,
  output logic [5:0] char_data,
  output logic       fifo_full
);

  // state | meaning
  // IDLE  | waiting for SLOW_OUT & T0      SHIFT | collecting digit + format bits
  // EMIT  | act on latched format (1 cyc)  HOLD  | FIFO full, retrying the push
  // DONE  | end/reload reached, STOP_OF    (SLOW_OUT low forces IDLE from any state)
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_EMIT, S_HOLD, S_DONE} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [2:0] F_DIGIT  = 3'b000;
  localparam logic [2:0] F_END    = 3'b001;
  localparam logic [2:0] F_CR     = 3'b010;
  localparam logic [2:0] F_PERIOD = 3'b011;
  localparam logic [2:0] F_SIGN   = 3'b100;
  localparam logic [2:0] F_RELOAD = 3'b101;
  localparam logic [2:0] F_TAB    = 3'b110;
  localparam logic [2:0] F_WAIT   = 3'b111;

  state_t      state, state_d;
  logic [3:0]  dig_sr, dig_sr_d;
  logic [2:0]  fmt_sr, fmt_sr_d;
  logic        dig_seen, fmt_seen;
  logic        dig_done, fmt_done, pair_done, shifting;
  logic        push_req, push_en, fmt_stop, can_push, pop;
  logic [4:0]  push_code;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [4:0]    head;
  logic          char_par;

  assign shifting  = (state == S_SHIFT);
  assign dig_done  = dig_seen | (shifting & DIGIT_STB);
  assign fmt_done  = fmt_seen | (shifting & FMT_STB);
  assign pair_done = shifting & dig_done & fmt_done;

  // Each register freezes once its own strobe has been seen, so it holds the finished group until EMIT.
  assign dig_sr_d = (shifting & ~dig_seen) ? {DATA_BIT, dig_sr[3:1]} : dig_sr;
  assign fmt_sr_d = (shifting & ~fmt_seen) ? {FMT_BIT, fmt_sr[2:1]} : fmt_sr;

  assign char_valid = (count != '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = char_valid & char_ready;
  assign can_push   = ~fifo_full | pop;

  always_comb begin
    push_req  = 1'b0;
    push_code = 5'h00;
    fmt_stop  = 1'b0;
    case (fmt_sr)
      F_DIGIT:  begin push_req = 1'b1;      push_code = {1'b0, dig_sr}; end
      F_CR:     begin push_req = 1'b1;      push_code = 5'h10; end
      F_TAB:    begin push_req = 1'b1;      push_code = 5'h11; end
      F_PERIOD: begin push_req = 1'b1;      push_code = 5'h12; end
      F_SIGN:   begin push_req = dig_sr[0]; push_code = 5'h13; end
      F_END, F_RELOAD: fmt_stop = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state;
    push_en = 1'b0;
    case (state)
      S_IDLE:  if (T0) state_d = S_SHIFT;
      S_SHIFT: if (pair_done) state_d = S_EMIT;
      S_EMIT: begin
        if (fmt_stop) begin
          state_d = S_DONE;
        end else if (push_req) begin
          push_en = can_push;
          state_d = can_push ? S_SHIFT : S_HOLD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_HOLD: begin
        if (can_push) begin
          push_en = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    if (!SLOW_OUT) begin
      state_d = S_IDLE;
      push_en = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      dig_sr    <= '0;
      fmt_sr    <= '0;
      dig_seen  <= 1'b0;
      fmt_seen  <= 1'b0;
      DIGIT_OF  <= 1'b0;
      WAIT_OF   <= 1'b0;
      CR_TAB_OF <= 1'b0;
    end else begin
      state    <= state_d;
      dig_sr   <= dig_sr_d;
      fmt_sr   <= fmt_sr_d;
      dig_seen <= shifting & dig_done & ~pair_done;
      fmt_seen <= shifting & fmt_done & ~pair_done;
      if (state_d == S_EMIT) begin
        DIGIT_OF  <= (fmt_sr_d == F_DIGIT);
        WAIT_OF   <= (fmt_sr_d == F_WAIT);
        CR_TAB_OF <= (fmt_sr_d == F_CR) || (fmt_sr_d == F_TAB);
      end else if (state_d == S_IDLE || state_d == S_DONE) begin
        DIGIT_OF  <= 1'b0;
        WAIT_OF   <= 1'b0;
        CR_TAB_OF <= 1'b0;
      end
    end
  end

  assign STOP_OF = (state == S_DONE);

  always_ff @(posedge CLOCK) begin
    if (push_en) mem[wr_ptr] <= push_code;
  end

  always_ff @(posedge CLOCK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

`ifdef IO_FMT_PARITY_EN
  assign char_par = ~^head;
`else
  assign char_par = 1'b0;
`endif

  // Gated so the output reads 0 while empty, including straight after an async reset.
  assign char_data = char_valid ? {char_par, head} : 6'h00;

endmodule

// File: tb/tb_io_format_decode.sv
// Directed bench for io_format_decode: stimulus tasks feed a spec-level character/flag model,
// a per-cycle compare process checks the DUT against it, and literal checks pin the model.
module tb_io_format_decode;
  localparam int DEPTH = 4;

  logic       CLOCK = 1'b0;
  logic       rst_n, T0, SLOW_OUT, DATA_BIT, FMT_BIT, DIGIT_STB, FMT_STB, char_ready;
  logic       DIGIT_OF, WAIT_OF, CR_TAB_OF, STOP_OF, char_valid, fifo_full;
  logic [5:0] char_data;

  int total = 0;
  int bad = 0;
  logic [5:0] exp_q[$];
  logic [5:0] popped[$];
  logic [5:0] want_q[$];
  logic exp_digit = 1'b0, exp_wait = 1'b0, exp_crtab = 1'b0, exp_stop = 1'b0;

  always #5 CLOCK = ~CLOCK;

  io_format_decode #(.DEPTH(DEPTH)) dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .T0(T0), .SLOW_OUT(SLOW_OUT),
    .DATA_BIT(DATA_BIT), .FMT_BIT(FMT_BIT), .DIGIT_STB(DIGIT_STB), .FMT_STB(FMT_STB),
    .char_ready(char_ready), .DIGIT_OF(DIGIT_OF), .WAIT_OF(WAIT_OF), .CR_TAB_OF(CR_TAB_OF),
    .STOP_OF(STOP_OF), .char_valid(char_valid), .char_data(char_data), .fifo_full(fifo_full)
  );

  function automatic logic [5:0] code6(input logic [4:0] c);
`ifdef IO_FMT_PARITY_EN
    return {~^c, c};
`else
    return {1'b0, c};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Per-cycle comparison against the model; handshakes consume the expected character queue.
  always @(negedge CLOCK) begin
    check("digit_of", DIGIT_OF, exp_digit);
    check("wait_of", WAIT_OF, exp_wait);
    check("cr_tab_of", CR_TAB_OF, exp_crtab);
    check("stop_of", STOP_OF, exp_stop);
    if (exp_q.size() == 0) check("char_valid_model_empty", char_valid, 0);
    if (char_valid && char_ready && exp_q.size() != 0) begin
      check("char_data", char_data, exp_q[0]);
      popped.push_back(char_data);
      void'(exp_q.pop_front());
    end
  end

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic start();
    tick();
    SLOW_OUT = 1'b1;
    T0 = 1'b1;
  endtask

  // One digit group; fmt_early puts the format code one cycle ahead of the digit strobe.
  task automatic send_group(input logic [3:0] dig, input logic [2:0] fmt, input logic fmt_early);
    logic [3:0] fbits;
    fbits = fmt_early ? {1'b0, fmt} : {fmt, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick();
      T0 = 1'b0;
      DATA_BIT = dig[i];
      FMT_BIT = fbits[i];
      FMT_STB = fmt_early ? (i == 2) : (i == 3);
      DIGIT_STB = (i == 3);
    end
    tick();
    DATA_BIT = 1'b0; FMT_BIT = 1'b0; DIGIT_STB = 1'b0; FMT_STB = 1'b0;
    exp_digit = (fmt == 3'b000);
    exp_wait  = (fmt == 3'b111);
    exp_crtab = (fmt == 3'b010) || (fmt == 3'b110);
    case (fmt)
      3'b000: exp_q.push_back(code6({1'b0, dig}));
      3'b010: exp_q.push_back(code6(5'h10));
      3'b110: exp_q.push_back(code6(5'h11));
      3'b011: exp_q.push_back(code6(5'h12));
      3'b100: if (dig[0]) exp_q.push_back(code6(5'h13));
      default: ;
    endcase
    if (fmt == 3'b001 || fmt == 3'b101) begin
      tick();
      exp_stop = 1'b1;
    end
  endtask

  task automatic stop_slow();
    tick();
    SLOW_OUT = 1'b0;
    tick();
    exp_digit = 1'b0; exp_wait = 1'b0; exp_crtab = 1'b0; exp_stop = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) tick();
    check("drain_left", exp_q.size(), 0);
    tick();
    check("drain_valid", char_valid, 0);
  endtask

  task automatic check_log(input string nm);
    check({nm, "_len"}, popped.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < popped.size(); i++) check(nm, popped[i], want_q[i]);
    popped.delete();
  endtask

  initial begin
    rst_n = 1'b0; T0 = 1'b0; SLOW_OUT = 1'b0; DATA_BIT = 1'b0; FMT_BIT = 1'b0;
    DIGIT_STB = 1'b0; FMT_STB = 1'b0; char_ready = 1'b1;
    #12;
    check("rst_valid", char_valid, 0);
    check("rst_full", fifo_full, 0);
    check("rst_data", char_data, 0);
    check("rst_stop", STOP_OF, 0);
    rst_n = 1'b1;

    // digits 5, 9 then end
    start();
    send_group(4'd5, 3'b000, 1'b0);
    send_group(4'd9, 3'b000, 1'b0);
    send_group(4'd0, 3'b001, 1'b0);
    tick();
    check("t1_stop", STOP_OF, 1);
    stop_slow();
    drain();
    want_q = {6'h05, 6'h09};
    check_log("t1_log");

    // CR (format first), tab, wait
    start();
    send_group(4'd1, 3'b010, 1'b1);
    check("t2_crtab_a", CR_TAB_OF, 1);
    send_group(4'd2, 3'b110, 1'b0);
    check("t2_crtab_b", CR_TAB_OF, 1);
    send_group(4'd3, 3'b111, 1'b0);
    check("t2_wait", WAIT_OF, 1);
    check("t2_crtab_c", CR_TAB_OF, 0);
    stop_slow();
    drain();
    want_q = {6'h10, 6'h11};
    check_log("t2_log");

    // sign with dig[0]=1 and 0, period, reload
    start();
    send_group(4'd1, 3'b100, 1'b0);
    send_group(4'd0, 3'b100, 1'b1);
    send_group(4'd7, 3'b011, 1'b0);
    send_group(4'd0, 3'b101, 1'b0);
    check("t3_stop", STOP_OF, 1);
    stop_slow();
    drain();
    want_q = {6'h13, 6'h12};
    check_log("t3_log");

    // FIFO fills, fifth push holds, release ready
    tick();
    char_ready = 1'b0;
    start();
    for (int d = 0; d < 5; d++) send_group(4'(d), 3'b000, 1'b0);
    repeat (3) tick();
    check("t4_full", fifo_full, 1);
    check("t4_valid", char_valid, 1);
    tick();
    char_ready = 1'b1;
    send_group(4'd5, 3'b000, 1'b0);
    stop_slow();
    drain();
    want_q = {6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
    check_log("t4_log");

    // SLOW_OUT dropped mid-digit; queued chars still drain
    tick();
    char_ready = 1'b0;
    start();
    send_group(4'd6, 3'b000, 1'b0);
    send_group(4'd8, 3'b000, 1'b0);
    tick(); DATA_BIT = 1'b1;
    tick(); DATA_BIT = 1'b0;
    stop_slow();
    check("t5_digit_of", DIGIT_OF, 0);
    check("t5_valid", char_valid, 1);
    char_ready = 1'b1;
    drain();
    want_q = {6'h06, 6'h08};
    check_log("t5_log");

    // async reset with 3 queued, then digit 3
    tick();
    char_ready = 1'b0;
    start();
    send_group(4'd1, 3'b000, 1'b0);
    send_group(4'd2, 3'b000, 1'b0);
    send_group(4'd3, 3'b000, 1'b0);
    tick();
    check("t6_valid_pre", char_valid, 1);
    #2;
    rst_n = 1'b0;
    SLOW_OUT = 1'b0;
    exp_q.delete();
    exp_digit = 1'b0; exp_wait = 1'b0; exp_crtab = 1'b0; exp_stop = 1'b0;
    #1;
    check("t6_valid_rst", char_valid, 0);
    check("t6_full_rst", fifo_full, 0);
    check("t6_digit_rst", DIGIT_OF, 0);
    tick();
    rst_n = 1'b1;
    char_ready = 1'b1;
    repeat (3) tick();
    check("t6_valid_post", char_valid, 0);
    start();
    send_group(4'd3, 3'b000, 1'b0);
    tick();
`ifdef IO_FMT_PARITY_EN
    check("t6_char3", char_data, 6'h23);
`else
    check("t6_char3", char_data, 6'h03);
`endif
    stop_slow();
    drain();
    want_q = {code6(5'h03)};
    check_log("t6_log");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
